// File: rtl/counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | counter_bank: bank of independent clear/load/enable counters with          |
// |               wrap or saturate limit handling and a one-cycle event pulse. |
// | Optional COUNTER_BANK_OVF_STICKY_EN adds sticky per-channel overflow flags.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module counter_bank #(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       CHANNELS = 2,
  parameter logic [WIDTH-1:0]  STEP     = WIDTH'(1),
  parameter logic [WIDTH-1:0]  LIMIT    = {WIDTH{1'b1}},
  parameter bit                SATURATE = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
`ifdef COUNTER_BANK_OVF_STICKY_EN
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic [CHANNELS-1:0]       ovf,
`endif
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       evt
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             evt_q;
    logic             evt_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] ld_clamped;

    // Extra carry bit keeps an overflowing sum visibly above LIMIT.
    assign sum        = {1'b0, cnt_q} + {1'b0, STEP};
    assign ld_val     = load_val[i*WIDTH +: WIDTH];
    assign ld_clamped = (ld_val > LIMIT) ? LIMIT : ld_val;

    always_comb begin
      cnt_d = cnt_q;
      evt_d = 1'b0;
      if (clr[i]) begin
        cnt_d = '0;
      end else if (load[i]) begin
        cnt_d = ld_clamped;
      end else if (en[i]) begin
        if (sum > {1'b0, LIMIT}) begin
          evt_d = 1'b1;
          cnt_d = SATURATE ? LIMIT : '0;
        end else begin
          cnt_d = sum[WIDTH-1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        evt_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        evt_q <= evt_d;
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign evt[i]                  = evt_q;

`ifdef COUNTER_BANK_OVF_STICKY_EN
    logic ovf_q;
    logic ovf_d;

    // A new event outranks a coincident clear request.
    assign ovf_d = evt_d | (ovf_q & ~ovf_clr[i]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_d;
      end
    end

    assign ovf[i] = ovf_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_counter_bank: four counter_bank configurations driven in parallel and   |
// |                  compared against a behavioural model each clock.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_counter_bank;

  localparam int NI = 4;
  localparam int NC = 2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  en;
  logic [1:0]  clr;
  logic [1:0]  load;
  logic [15:0] load_val;
  logic [15:0] c0, c1, c2, c3;
  logic [1:0]  e0, e1, e2, e3;
`ifdef COUNTER_BANK_OVF_STICKY_EN
  logic [1:0]  ovf_clr;
  logic [1:0]  o0, o1, o2, o3;
`endif

  int checks   = 0;
  int failures = 0;

  // Instance configs: defaults / wrap L9 S4 / saturate L9 S4 / wrap L100 S3
  int lim_t [NI] = '{255, 9, 9, 100};
  int stp_t [NI] = '{1, 4, 4, 3};
  bit sat_t [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

  int m_cnt [NI][NC];
  bit m_evt [NI][NC];
  bit m_ovf [NI][NC];

  counter_bank u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
`ifdef COUNTER_BANK_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(o0),
`endif
    .count(c0), .evt(e0));

  counter_bank #(.WIDTH(8), .CHANNELS(2), .STEP(8'd4), .LIMIT(8'd9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
`ifdef COUNTER_BANK_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(o1),
`endif
    .count(c1), .evt(e1));

  counter_bank #(.WIDTH(8), .CHANNELS(2), .STEP(8'd4), .LIMIT(8'd9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
`ifdef COUNTER_BANK_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(o2),
`endif
    .count(c2), .evt(e2));

  counter_bank #(.WIDTH(8), .CHANNELS(2), .STEP(8'd3), .LIMIT(8'd100), .SATURATE(1'b0)) u_lim (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
`ifdef COUNTER_BANK_OVF_STICKY_EN
    .ovf_clr(ovf_clr), .ovf(o3),
`endif
    .count(c3), .evt(e3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dut_cnt(input int k, input int ch);
    logic [15:0] v;
    case (k)
      0:       v = c0;
      1:       v = c1;
      2:       v = c2;
      default: v = c3;
    endcase
    return int'(v[ch*8 +: 8]);
  endfunction

  function automatic bit dut_evt(input int k, input int ch);
    logic [1:0] v;
    case (k)
      0:       v = e0;
      1:       v = e1;
      2:       v = e2;
      default: v = e3;
    endcase
    return v[ch];
  endfunction

`ifdef COUNTER_BANK_OVF_STICKY_EN
  function automatic bit dut_ovf(input int k, input int ch);
    logic [1:0] v;
    case (k)
      0:       v = o0;
      1:       v = o1;
      2:       v = o2;
      default: v = o3;
    endcase
    return v[ch];
  endfunction
`endif

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++)
      for (int ch = 0; ch < NC; ch++) begin
        m_cnt[k][ch] = 0;
        m_evt[k][ch] = 1'b0;
        m_ovf[k][ch] = 1'b0;
      end
  endtask

  // Applies the rules for one clock edge using the inputs held at that edge.
  task automatic model_step();
    int lv;
    int s;
    for (int k = 0; k < NI; k++)
      for (int ch = 0; ch < NC; ch++) begin
        bit ev;
        ev = 1'b0;
        lv = int'(load_val[ch*8 +: 8]);
        if (clr[ch]) begin
          m_cnt[k][ch] = 0;
        end else if (load[ch]) begin
          m_cnt[k][ch] = (lv < lim_t[k]) ? lv : lim_t[k];
        end else if (en[ch]) begin
          s = m_cnt[k][ch] + stp_t[k];
          if (s > lim_t[k]) begin
            ev = 1'b1;
            m_cnt[k][ch] = sat_t[k] ? lim_t[k] : 0;
          end else begin
            m_cnt[k][ch] = s;
          end
        end
        m_evt[k][ch] = ev;
`ifdef COUNTER_BANK_OVF_STICKY_EN
        m_ovf[k][ch] = ev | (m_ovf[k][ch] & ~ovf_clr[ch]);
`endif
      end
  endtask

  task automatic check_all(input string phase);
    for (int k = 0; k < NI; k++)
      for (int ch = 0; ch < NC; ch++) begin
        check($sformatf("%s cnt i%0d c%0d", phase, k, ch), dut_cnt(k, ch), m_cnt[k][ch]);
        check($sformatf("%s evt i%0d c%0d", phase, k, ch), int'(dut_evt(k, ch)), int'(m_evt[k][ch]));
`ifdef COUNTER_BANK_OVF_STICKY_EN
        check($sformatf("%s ovf i%0d c%0d", phase, k, ch), int'(dut_ovf(k, ch)), int'(m_ovf[k][ch]));
`endif
      end
  endtask

  task automatic tick(input string phase);
    @(posedge clk);
    #1;
    model_step();
    check_all(phase);
  endtask

  initial begin
    int wseq [5] = '{4, 8, 0, 4, 8};
    int weq  [5] = '{0, 0, 1, 0, 0};
    int sseq [5] = '{4, 8, 9, 9, 9};
    int seq_e[5] = '{0, 0, 1, 1, 1};
    int pulses;

    rst_n    = 1'b0;
    en       = '0;
    clr      = '0;
    load     = '0;
    load_val = '0;
`ifdef COUNTER_BANK_OVF_STICKY_EN
    ovf_clr  = '0;
`endif
    model_reset();
    #3;
    check_all("reset");

    // Long run on channel 0 only: full wrap of the default instance.
    @(negedge clk);
    rst_n  = 1'b1;
    en     = 2'b01;
    pulses = 0;
    for (int c = 0; c < 256; c++) begin
      tick("run");
      if (dut_evt(0, 0)) pulses++;
      if (c < 5) begin
        check($sformatf("wrapseq cnt %0d", c), dut_cnt(1, 0), wseq[c]);
        check($sformatf("wrapseq evt %0d", c), int'(dut_evt(1, 0)), weq[c]);
        check($sformatf("satseq cnt %0d", c), dut_cnt(2, 0), sseq[c]);
        check($sformatf("satseq evt %0d", c), int'(dut_evt(2, 0)), seq_e[c]);
      end
    end
    check("def wrap count", dut_cnt(0, 0), 0);
    check("def evt pulses", pulses, 1);
    check("def ch1 idle", dut_cnt(0, 1), 0);

    // Load above LIMIT clamps; then clr beats load and en on the same edge.
    en       = 2'b00;
    load     = 2'b11;
    load_val = {8'd200, 8'd200};
    tick("load");
    check("load clamp", dut_cnt(3, 0), 100);
    clr  = 2'b11;
    load = 2'b11;
    en   = 2'b11;
    tick("clrprio");
    check("clr prio cnt", dut_cnt(3, 0), 0);
    check("clr prio evt", int'(dut_evt(3, 0)), 0);

    // Asynchronous reset between edges at count 37.
    clr      = 2'b00;
    en       = 2'b00;
    load     = 2'b11;
    load_val = {8'd37, 8'd37};
    tick("load37");
    check("at 37", dut_cnt(0, 0), 37);
    load = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("asyncrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick("postrst");
    check("post release", dut_cnt(3, 0), 0);

    // Randomized mix of per-channel controls.
    for (int c = 0; c < 400; c++) begin
      for (int ch = 0; ch < NC; ch++) begin
        en[ch]   = ($urandom_range(0, 3) != 0);
        clr[ch]  = ($urandom_range(0, 15) == 0);
        load[ch] = ($urandom_range(0, 9) == 0);
`ifdef COUNTER_BANK_OVF_STICKY_EN
        ovf_clr[ch] = ($urandom_range(0, 3) == 0);
`endif
      end
      load_val = 16'($urandom);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
